// File: rtl/gpu_capability_arbiter_pkg.sv
// Shared definitions for the GPU capability arbiter and its round-robin picker.
// Holds the capability word width, FSM state encoding, the defined capability
// addresses and the words the capability table returns for them.
package gpu_capability_arbiter_pkg;

   localparam int GPU_WORD_W = 32;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_LOOKUP  = 2'd1,
      ARB_RESPOND = 2'd2
   } arb_state_e;

   // Defined capability table addresses.
   localparam logic [4:0] CAP_ADDR_AABB_COUNT = 5'd0;
   localparam logic [4:0] CAP_ADDR_SCALE      = 5'd1;

   // Contents of the capability table (the table itself lives at GPU top).
   localparam logic [4:0]            GPU_AABB_COUNT       = 5'd12;
   localparam logic [GPU_WORD_W-1:0] GPU_SCALE_WORD       = 32'h0001_0000;
   localparam logic [GPU_WORD_W-1:0] GPU_CAP_DEFAULT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/gpu_capability_arbiter_rr_picker.sv
// Combinational round-robin priority picker.
// Ports:
//   req_i   - request vector
//   ptr_i   - index of the last winner; search starts at ptr_i+1 (mod NUM_REQ)
//   mask_i  - requesters excluded from this pick
//   valid_o - at least one unmasked request exists
//   idx_o   - index of the winning requester (0 when valid_o is low)
module gpu_capability_arbiter_rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   input  logic [NUM_REQ-1:0] mask_i,
   output logic               valid_o,
   output logic [IDX_W-1:0]   idx_o
);

   logic [NUM_REQ-1:0] eligible;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
         assign eligible[gi] = req_i[gi] & ~mask_i[gi];
      end
   endgenerate

   // Walk offsets from farthest to nearest so the nearest eligible requester
   // after the pointer is the last one written; offset NUM_REQ is the pointer
   // itself, which therefore has the lowest priority.
   always_comb begin
      int cand;
      valid_o = 1'b0;
      idx_o   = '0;
      cand    = 0;
      for (int off = NUM_REQ; off >= 1; off--) begin
         cand = int'(ptr_i) + off;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (eligible[cand[IDX_W-1:0]]) begin
            valid_o = 1'b1;
            idx_o   = cand[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/gpu_capability_arbiter.sv
// Round-robin arbiter sharing the combinational GPU capability table among
// NUM_REQ requesters. A granted address is registered onto cap_addr_o, the
// returned word is captured one cycle later, and the transaction completes
// with a one-cycle one-hot acknowledge.
// Ports:
//   clk_i       - system clock, rising edge
//   rst_ni      - asynchronous active-low reset
//   req_i       - per-requester request level
//   addr_i      - per-requester address, requester k at [k*ADDR_W +: ADDR_W]
//   ack_o       - one-hot, one-cycle completion pulse
//   data_o      - captured capability word, valid while ack_o != 0
//   err_o       - served address was >= CAP_ENTRIES (with ack_o)
//   busy_o      - a transaction is in LOOKUP or RESPOND
//   cap_addr_o  - registered address to the capability table
//   cap_data_i  - combinational data from the capability table
module gpu_capability_arbiter
   import gpu_capability_arbiter_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int CAP_ENTRIES = 2,
   parameter int ADDR_W      = 5
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [NUM_REQ*ADDR_W-1:0]  addr_i,
   output logic [NUM_REQ-1:0]         ack_o,
   output logic [GPU_WORD_W-1:0]      data_o,
   output logic                       err_o,
   output logic                       busy_o,
   output logic [ADDR_W-1:0]          cap_addr_o,
   input  logic [GPU_WORD_W-1:0]      cap_data_i
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [ADDR_W:0] CAP_LIMIT = (ADDR_W+1)'(CAP_ENTRIES);

   arb_state_e              state_q;
   logic [IDX_W-1:0]        ptr_q;
   logic [IDX_W-1:0]        grant_q;
   logic [ADDR_W-1:0]       cap_addr_q;
   logic [NUM_REQ-1:0]      ack_q;
   logic [GPU_WORD_W-1:0]   data_q;
   logic                    err_q;

   logic [ADDR_W-1:0]       addr_arr [NUM_REQ];
   logic [NUM_REQ-1:0]      grant_onehot;
   logic [NUM_REQ-1:0]      pick_mask;
   logic                    pick_valid;
   logic [IDX_W-1:0]        pick_idx;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
         assign addr_arr[gi] = addr_i[gi*ADDR_W +: ADDR_W];
      end
   endgenerate

   assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;

   // In RESPOND the requester being acknowledged may still hold its request
   // for this cycle; masking it avoids serving it twice.
   assign pick_mask = (state_q == ARB_RESPOND) ? grant_onehot : '0;

   gpu_capability_arbiter_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .mask_i  (pick_mask),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ARB_IDLE;
         ptr_q      <= '0;
         grant_q    <= '0;
         cap_addr_q <= '0;
         ack_q      <= '0;
         data_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               ack_q <= '0;
               err_q <= 1'b0;
               if (pick_valid) begin
                  grant_q    <= pick_idx;
                  ptr_q      <= pick_idx;
                  cap_addr_q <= addr_arr[pick_idx];
                  state_q    <= ARB_LOOKUP;
               end
            end
            ARB_LOOKUP: begin
               // Out-of-range words are passed through unaltered; only err flags them.
               data_q  <= cap_data_i;
               err_q   <= ({1'b0, cap_addr_q} >= CAP_LIMIT);
               ack_q   <= grant_onehot;
               state_q <= ARB_RESPOND;
            end
            ARB_RESPOND: begin
               ack_q <= '0;
               err_q <= 1'b0;
               if (pick_valid) begin
                  grant_q    <= pick_idx;
                  ptr_q      <= pick_idx;
                  cap_addr_q <= addr_arr[pick_idx];
                  state_q    <= ARB_LOOKUP;
               end else begin
                  state_q <= ARB_IDLE;
               end
            end
            default: begin
               ack_q   <= '0;
               err_q   <= 1'b0;
               state_q <= ARB_IDLE;
            end
         endcase
      end
   end

   assign ack_o      = ack_q;
   assign data_o     = data_q;
   assign err_o      = err_q;
   assign busy_o     = (state_q != ARB_IDLE);
   assign cap_addr_o = cap_addr_q;

endmodule
